sdram_frame_sched: RTL

- Upstream command scheduler for the SDRAM controller in the Dsync frame-buffer path.
- On each frame-start pulse, walks the frame row by row and issues one-cycle activate strobes, one per row slot, for write frames (Act_start) or read frames (ActR_start).
- Drives row/column/bank/direction to the controller and ping-pongs banks so display reads never hit the bank being written.
- Holds off all requests until the controller's power-up init sequence has finished.

---
 rtl/sdram_pkg.sv | 16 +
 rtl/sched_slot_timer.sv | 28 ++
 rtl/sdram_frame_sched.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Shared constants and types for the SDRAM frame-buffer command path.
package sdram_pkg;

  localparam int unsigned ROWS_DEFAULT    = 1080;
  localparam int unsigned ROW_IDLE        = ROWS_DEFAULT + 1;
  localparam int unsigned BANK_W          = 3;
  localparam int unsigned ADDR_W          = 11;
  localparam int unsigned MIN_SLOT_CYCLES = 20;

  typedef enum logic [1:0] {
    WAIT_INIT,
    IDLE,
    RUN
  } sched_state_e;

endpackage

// File: rtl/sched_slot_timer.sv
// Modulo-N counter with enable and synchronous clear; wrap is high on the
// enabled cycle in which the count rolls from N-1 back to 0.
module sched_slot_timer #(
  parameter int unsigned N = 24,
  parameter int unsigned W = $clog2(N)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count;

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/sdram_frame_sched.sv
// Frame-level activate scheduler: one row strobe per slot, write/read bank
// ping-pong, and request hold-off until controller init has completed.
module sdram_frame_sched
  import sdram_pkg::*;
#(
  parameter int unsigned ROWS        = ROWS_DEFAULT,
  parameter int unsigned SLOT_CYCLES = 24,
  parameter int unsigned INIT_CYCLES = 40300,
  parameter int unsigned COL_START   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              frame_rd,
  output logic              RorW,
  output logic              Act_start,
  output logic              ActR_start,
  output logic [ADDR_W-1:0] row_cnt,
  output logic [ADDR_W-1:0] col_cnt,
  output logic [BANK_W-1:0] BA_cnt,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam int unsigned       SLOT_W   = $clog2(SLOT_CYCLES);
  localparam int unsigned       INIT_W   = $clog2(INIT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_OFF  = ADDR_W'(ROWS + 1);
  localparam logic [ADDR_W-1:0] COL_INIT = ADDR_W'(COL_START);

  if (ROWS + 1 > (2 ** ADDR_W) - 1) begin : g_rows_chk
    $error("sdram_frame_sched: ROWS+1 does not fit in row_cnt");
  end
  if (SLOT_CYCLES < MIN_SLOT_CYCLES) begin : g_slot_chk
    $error("sdram_frame_sched: SLOT_CYCLES shorter than controller sequence");
  end

  sched_state_e state_q, state_d;

  logic              wr_bank, wr_bank_d;
  logic              rd_bank, rd_bank_d;
  logic              slot_due;
  logic              init_en, init_wrap;
  logic              slot_en, slot_clr, slot_wrap;
  logic              rorw_d, act_d, actr_d, busy_d, done_d, overrun_d;
  logic [ADDR_W-1:0] row_d;
  logic [BANK_W-1:0] ba_d;

  sched_slot_timer #(.N(INIT_CYCLES), .W(INIT_W)) u_init_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .en    (init_en),
    .wrap  (init_wrap)
  );

  sched_slot_timer #(.N(SLOT_CYCLES), .W(SLOT_W)) u_slot_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (slot_clr),
    .en    (slot_en),
    .wrap  (slot_wrap)
  );

  // slot_due marks the cycle the slot count sits at 0, so that strobes
  // registered from it land exactly SLOT_CYCLES apart starting at T+1.
  always_comb begin
    state_d   = state_q;
    rorw_d    = RorW;
    act_d     = 1'b0;
    actr_d    = 1'b0;
    row_d     = row_cnt;
    ba_d      = BA_cnt;
    busy_d    = busy;
    done_d    = 1'b0;
    overrun_d = 1'b0;
    wr_bank_d = wr_bank;
    rd_bank_d = rd_bank;
    init_en   = 1'b0;
    slot_en   = 1'b0;
    slot_clr  = 1'b0;

    unique case (state_q)
      WAIT_INIT: begin
        init_en   = 1'b1;
        slot_clr  = 1'b1;
        overrun_d = frame_start;
        if (init_wrap) state_d = IDLE;
      end
      IDLE: begin
        if (frame_start) begin
          state_d = RUN;
          rorw_d  = frame_rd;
          ba_d    = BANK_W'(frame_rd ? rd_bank : wr_bank);
          row_d   = '0;
          busy_d  = 1'b1;
          act_d   = ~frame_rd;
          actr_d  = frame_rd;
          slot_en = 1'b1;
        end else begin
          slot_clr = 1'b1;
        end
      end
      RUN: begin
        slot_en   = 1'b1;
        overrun_d = frame_start;
        if (slot_due) begin
          if (row_cnt < ROW_LAST) begin
            row_d  = row_cnt + ADDR_W'(1);
            act_d  = ~RorW;
            actr_d = RorW;
          end else begin
            state_d  = IDLE;
            row_d    = ROW_OFF;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            slot_clr = 1'b1;
            if (!RorW) begin
              rd_bank_d = wr_bank;
              wr_bank_d = ~wr_bank;
            end
          end
        end
      end
      default: state_d = WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= WAIT_INIT;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b1;
      slot_due   <= 1'b0;
      RorW       <= 1'b0;
      Act_start  <= 1'b0;
      ActR_start <= 1'b0;
      row_cnt    <= ROW_OFF;
      col_cnt    <= COL_INIT;
      BA_cnt     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_bank    <= wr_bank_d;
      rd_bank    <= rd_bank_d;
      slot_due   <= slot_wrap;
      RorW       <= rorw_d;
      Act_start  <= act_d;
      ActR_start <= actr_d;
      row_cnt    <= row_d;
      col_cnt    <= COL_INIT;
      BA_cnt     <= ba_d;
      busy       <= busy_d;
      frame_done <= done_d;
      overrun    <= overrun_d;
    end
  end

endmodule
